// File: rtl/mdu_pkg.sv
// Shared encodings and constants for the iterative multiply/divide unit.
package mdu_pkg;

    localparam int MDU_DATA_W = 32;
    localparam logic [31:0] DIV0_QUOT = 32'hFFFFFFFF;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } mdu_op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        CALC  = 2'b01,
        FIXUP = 2'b10
    } mdu_state_e;

endpackage

// File: rtl/mdu_iter_step.sv
// One shift-add (multiply) or restoring-subtract (divide) iteration on unsigned magnitudes.
module mdu_iter_step #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] acc_i,
    input  logic [DATA_W-1:0] reg_i,
    input  logic [DATA_W-1:0] opnd_i,
    input  logic              is_div_i,
    output logic [DATA_W-1:0] acc_o,
    output logic [DATA_W-1:0] reg_o,
    output logic              qbit_o
);

    logic [DATA_W:0] sum;
    logic [DATA_W:0] shifted;

    assign sum     = {1'b0, acc_i} + (reg_i[0] ? {1'b0, opnd_i} : '0);
    assign shifted = {acc_i, reg_i[DATA_W-1]};

    // Divide leaves the register LSB clear; the caller ORs the quotient bit in.
    always_comb begin
        if (is_div_i) begin
            qbit_o = (shifted >= {1'b0, opnd_i});
            acc_o  = qbit_o ? DATA_W'(shifted - {1'b0, opnd_i}) : shifted[DATA_W-1:0];
            reg_o  = {reg_i[DATA_W-2:0], 1'b0};
        end else begin
            qbit_o = 1'b0;
            acc_o  = sum[DATA_W:1];
            reg_o  = {sum[0], reg_i[DATA_W-1:1]};
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit holding HI/LO; result lands 34 edges after start.
// Optional flush input enabled by defining MDU_ABORT_EN.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int DATA_W = MDU_DATA_W,
    parameter int CNT_W  = 6
) (
    input  logic              clk,
    input  logic              rst_n,
`ifdef MDU_ABORT_EN
    input  logic              abort,
`endif
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] Read_data1,
    input  logic [DATA_W-1:0] Read_data2,
    input  logic              hi_we,
    input  logic              lo_we,
    input  logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic              done,
    output logic              div0,
    output logic [DATA_W-1:0] HI,
    output logic [DATA_W-1:0] LO
);

    mdu_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] acc_q, acc_d, mq_q, mq_d, opnd_q, opnd_d, araw_q, araw_d;
    logic              isdiv_q, isdiv_d, qneg_q, qneg_d, rneg_q, rneg_d, dz_q, dz_d;
    logic              fin_q, fin_d;
    logic [DATA_W-1:0] reshi_q, reshi_d, reslo_q, reslo_d;
    logic              busy_q, busy_d, done_q, done_d, div0_q, div0_d;
    logic [DATA_W-1:0] hi_q, hi_d, lo_q, lo_d;

    logic [DATA_W-1:0]   step_acc, step_reg;
    logic                step_qbit;
    logic                sgn, a_neg, b_neg;
    logic [DATA_W-1:0]   mag_a, mag_b;
    logic [2*DATA_W-1:0] prod, prod_fix;
    logic [DATA_W-1:0]   quo_fix, rem_fix;

    mdu_iter_step #(.DATA_W(DATA_W)) u_step (
        .acc_i    (acc_q),
        .reg_i    (mq_q),
        .opnd_i   (opnd_q),
        .is_div_i (isdiv_q),
        .acc_o    (step_acc),
        .reg_o    (step_reg),
        .qbit_o   (step_qbit)
    );

    assign sgn   = (op == OP_MULT) || (op == OP_DIV);
    assign a_neg = sgn & Read_data1[DATA_W-1];
    assign b_neg = sgn & Read_data2[DATA_W-1];
    assign mag_a = a_neg ? -Read_data1 : Read_data1;
    assign mag_b = b_neg ? -Read_data2 : Read_data2;

    assign prod     = {acc_q, mq_q};
    assign prod_fix = qneg_q ? -prod : prod;
    assign quo_fix  = qneg_q ? -mq_q : mq_q;
    assign rem_fix  = rneg_q ? -acc_q : acc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        mq_d    = mq_q;
        opnd_d  = opnd_q;
        araw_d  = araw_q;
        isdiv_d = isdiv_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        dz_d    = dz_q;
        fin_d   = 1'b0;
        reshi_d = reshi_q;
        reslo_d = reslo_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        div0_d  = div0_q;
        hi_d    = hi_q;
        lo_d    = lo_q;

        case (state_q)
            IDLE: begin
                // busy_q is still high in the commit-pending cycle after FIXUP
                if (start && !busy_q) begin
                    state_d = CALC;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    acc_d   = '0;
                    isdiv_d = op[1];
                    mq_d    = op[1] ? mag_a : mag_b;
                    opnd_d  = op[1] ? mag_b : mag_a;
                    araw_d  = Read_data1;
                    qneg_d  = a_neg ^ b_neg;
                    rneg_d  = a_neg;
                    dz_d    = op[1] && (Read_data2 == '0);
                end
            end
            CALC: begin
                acc_d = step_acc;
                mq_d  = step_reg | DATA_W'(step_qbit);
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(DATA_W-1)) state_d = FIXUP;
            end
            FIXUP: begin
                state_d = IDLE;
                cnt_d   = '0;
                fin_d   = 1'b1;
                if (!isdiv_q) begin
                    reshi_d = prod_fix[2*DATA_W-1:DATA_W];
                    reslo_d = prod_fix[DATA_W-1:0];
                end else if (dz_q) begin
                    reshi_d = araw_q;
                    reslo_d = DATA_W'(DIV0_QUOT);
                end else begin
                    reshi_d = rem_fix;
                    reslo_d = quo_fix;
                end
            end
            default: state_d = IDLE;
        endcase

        if (fin_q) begin
            hi_d   = reshi_q;
            lo_d   = reslo_q;
            done_d = 1'b1;
            busy_d = 1'b0;
            if (isdiv_q) div0_d = dz_q;
        end else if (!busy_q) begin
            if (hi_we) hi_d = wdata;
            if (lo_we) lo_d = wdata;
        end

`ifdef MDU_ABORT_EN
        if (abort && (state_q == CALC || state_q == FIXUP)) begin
            state_d = IDLE;
            cnt_d   = '0;
            fin_d   = 1'b0;
            busy_d  = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            acc_q   <= '0;
            mq_q    <= '0;
            opnd_q  <= '0;
            araw_q  <= '0;
            isdiv_q <= 1'b0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            dz_q    <= 1'b0;
            fin_q   <= 1'b0;
            reshi_q <= '0;
            reslo_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            div0_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            mq_q    <= mq_d;
            opnd_q  <= opnd_d;
            araw_q  <= araw_d;
            isdiv_q <= isdiv_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            dz_q    <= dz_d;
            fin_q   <= fin_d;
            reshi_q <= reshi_d;
            reslo_q <= reslo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            div0_q  <= div0_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign div0 = div0_q;
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit (abort scenario when MDU_ABORT_EN is defined).
module tb_mult_div_unit;
    import mdu_pkg::*;

    logic        clk, rst_n, start, hi_we, lo_we, abort;
    logic [1:0]  op;
    logic [31:0] Read_data1, Read_data2, wdata;
    logic        busy, done, div0;
    logic [31:0] HI, LO;
    int          n_chk, n_fail;

    mult_div_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
`ifdef MDU_ABORT_EN
        .abort      (abort),
`endif
        .start      (start),
        .op         (op),
        .Read_data1 (Read_data1),
        .Read_data2 (Read_data2),
        .hi_we      (hi_we),
        .lo_we      (lo_we),
        .wdata      (wdata),
        .busy       (busy),
        .done       (done),
        .div0       (div0),
        .HI         (HI),
        .LO         (LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, required end of test");
        $fatal(1, "watchdog");
    end

    // Drives one start pulse; returns #1 after the sampling edge E0, operands scrambled.
    task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1; op = o; Read_data1 = a; Read_data2 = b;
        @(posedge clk); #1;
        start = 1'b0; op = ~o; Read_data1 = 32'hDEADBEEF; Read_data2 = 32'h0;
    endtask

    // Waits for done, bounded; lat = edges after E0, or -1 on timeout.
    task automatic wait_done(output int lat);
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (done) begin lat = k; break; end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; op = 2'b00; hi_we = 1'b0; lo_we = 1'b0; abort = 1'b0;
        Read_data1 = '0; Read_data2 = '0; wdata = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        n_chk++;
        if ({HI, LO, busy, done, div0} !== 67'd0) begin
            n_fail++;
            $display("FAIL reset_state: HI=%h LO=%h busy=%b done=%b div0=%b required all zero", HI, LO, busy, done, div0);
        end
    endtask

    task automatic test_mult;
        int lat;
        launch(OP_MULT, 32'd7, 32'hFFFFFFFD);
        n_chk++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL mult_busy_e0: busy=%b required 1", busy); end
        lat = -1;
        for (int k = 1; k <= 34; k++) begin
            @(posedge clk); #1;
            n_chk++;
            if (k < 34 && (busy !== 1'b1 || done !== 1'b0)) begin
                n_fail++; $display("FAIL mult_busy_k%0d: busy=%b done=%b required 1/0", k, busy, done);
            end else if (k == 34 && (busy !== 1'b0 || done !== 1'b1)) begin
                n_fail++; $display("FAIL mult_done_e34: busy=%b done=%b required 0/1", busy, done);
            end
        end
        n_chk++;
        if (HI !== 32'hFFFFFFFF || LO !== 32'hFFFFFFEB) begin
            n_fail++; $display("FAIL mult_result: HI=%h LO=%h required FFFFFFFF/FFFFFFEB", HI, LO);
        end
        @(posedge clk); #1;
        n_chk++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL mult_done_pulse: done=%b required 0", done); end
    endtask

    task automatic test_multu;
        int lat;
        launch(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_done(lat);
        n_chk++;
        if (lat != 34 || HI !== 32'hFFFFFFFE || LO !== 32'h00000001) begin
            n_fail++; $display("FAIL multu: lat=%0d HI=%h LO=%h required 34 FFFFFFFE/00000001", lat, HI, LO);
        end
    endtask

    task automatic test_div;
        int lat;
        launch(OP_DIV, 32'hFFFFFFF9, 32'd2);
        wait_done(lat);
        n_chk++;
        if (lat != 34 || HI !== 32'hFFFFFFFF || LO !== 32'hFFFFFFFD) begin
            n_fail++; $display("FAIL div_neg: lat=%0d HI=%h LO=%h required 34 FFFFFFFF/FFFFFFFD", lat, HI, LO);
        end
        launch(OP_DIV, 32'h80000000, 32'hFFFFFFFF);
        wait_done(lat);
        n_chk++;
        if (lat != 34 || HI !== 32'h0 || LO !== 32'h80000000 || div0 !== 1'b0) begin
            n_fail++; $display("FAIL div_ovf: lat=%0d HI=%h LO=%h div0=%b required 34 0/80000000/0", lat, HI, LO, div0);
        end
    endtask

    task automatic test_div0;
        int lat;
        launch(OP_DIVU, 32'd100, 32'd0);
        wait_done(lat);
        n_chk++;
        if (lat != 34 || HI !== 32'd100 || LO !== 32'hFFFFFFFF || div0 !== 1'b1) begin
            n_fail++; $display("FAIL divu_zero: lat=%0d HI=%h LO=%h div0=%b required 34 64/FFFFFFFF/1", lat, HI, LO, div0);
        end
        launch(OP_DIV, 32'hFFFFFFF9, 32'd0);
        wait_done(lat);
        n_chk++;
        if (HI !== 32'hFFFFFFF9 || LO !== 32'hFFFFFFFF || div0 !== 1'b1) begin
            n_fail++; $display("FAIL div_zero_signed: HI=%h LO=%h div0=%b required FFFFFFF9/FFFFFFFF/1", HI, LO, div0);
        end
        launch(OP_MULT, 32'd2, 32'd3);
        wait_done(lat);
        n_chk++;
        if (HI !== 32'd0 || LO !== 32'd6 || div0 !== 1'b1) begin
            n_fail++; $display("FAIL mult_keeps_div0: HI=%h LO=%h div0=%b required 0/6/1", HI, LO, div0);
        end
        launch(OP_DIVU, 32'd9, 32'd4);
        wait_done(lat);
        n_chk++;
        if (HI !== 32'd1 || LO !== 32'd2 || div0 !== 1'b0) begin
            n_fail++; $display("FAIL divu_clears_div0: HI=%h LO=%h div0=%b required 1/2/0", HI, LO, div0);
        end
    endtask

    task automatic test_busy_ignore;
        int lat;
        launch(OP_MULTU, 32'd3, 32'd5);
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            if (k == 5) begin start = 1'b1; op = OP_DIVU; hi_we = 1'b1; wdata = 32'hAAAA; end
            @(posedge clk); #1;
            start = 1'b0; hi_we = 1'b0;
            if (done) begin lat = k; break; end
        end
        n_chk++;
        if (lat != 34 || HI !== 32'd0 || LO !== 32'd15) begin
            n_fail++; $display("FAIL busy_ignore: lat=%0d HI=%h LO=%h required 34 0/F", lat, HI, LO);
        end
        @(posedge clk); #1;
        n_chk++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++; $display("FAIL no_queue: busy=%b done=%b required 0/0", busy, done);
        end
        hi_we = 1'b1; wdata = 32'hAAAA;
        @(posedge clk); #1;
        hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h5555;
        n_chk++;
        if (HI !== 32'hAAAA || LO !== 32'd15) begin
            n_fail++; $display("FAIL mthi_idle: HI=%h LO=%h required AAAA/F", HI, LO);
        end
        @(posedge clk); #1;
        lo_we = 1'b0;
        n_chk++;
        if (HI !== 32'hAAAA || LO !== 32'h5555) begin
            n_fail++; $display("FAIL mtlo_idle: HI=%h LO=%h required AAAA/5555", HI, LO);
        end
        hi_we = 1'b1; wdata = 32'h1234;
        launch(OP_MULTU, 32'd2, 32'd2);
        hi_we = 1'b0;
        n_chk++;
        if (HI !== 32'h1234) begin n_fail++; $display("FAIL mthi_with_start: HI=%h required 1234", HI); end
        wait_done(lat);
        n_chk++;
        if (lat != 34 || HI !== 32'd0 || LO !== 32'd4) begin
            n_fail++; $display("FAIL start_overwrites: lat=%0d HI=%h LO=%h required 34 0/4", lat, HI, LO);
        end
    endtask

    task automatic test_back_to_back;
        int lat;
        launch(OP_MULTU, 32'd10, 32'd10);
        wait_done(lat);
        launch(OP_MULTU, 32'd6, 32'd7);
        n_chk++;
        if (lat != 34 || LO !== 32'd100 || busy !== 1'b1) begin
            n_fail++; $display("FAIL b2b_first: lat=%0d LO=%h busy=%b required 34 64/1", lat, LO, busy);
        end
        wait_done(lat);
        n_chk++;
        if (lat != 34 || HI !== 32'd0 || LO !== 32'd42) begin
            n_fail++; $display("FAIL b2b_second: lat=%0d HI=%h LO=%h required 34 0/2A", lat, HI, LO);
        end
    endtask

    task automatic test_reset_mid;
        launch(OP_MULT, 32'd123, 32'd456);
        repeat (10) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        n_chk++;
        if ({HI, LO, busy, done, div0} !== 67'd0) begin
            n_fail++; $display("FAIL reset_mid: HI=%h LO=%h busy=%b done=%b div0=%b required all zero", HI, LO, busy, done, div0);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        n_chk++;
        if ({HI, LO, busy, done} !== 66'd0) begin
            n_fail++; $display("FAIL reset_no_result: HI=%h LO=%h busy=%b done=%b required all zero", HI, LO, busy, done);
        end
    endtask

`ifdef MDU_ABORT_EN
    task automatic test_abort;
        int lat;
        bit seen;
        launch(OP_MULTU, 32'd2, 32'd3);
        wait_done(lat);
        launch(OP_MULT, 32'd9, 32'd9);
        repeat (5) @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        n_chk++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++; $display("FAIL abort_busy: busy=%b done=%b required 0/0", busy, done);
        end
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (done) seen = 1'b1;
        end
        n_chk++;
        if (seen || HI !== 32'd0 || LO !== 32'd6) begin
            n_fail++; $display("FAIL abort_keep: done_seen=%b HI=%h LO=%h required 0 0/6", seen, HI, LO);
        end
    endtask
`endif

    initial begin
        n_chk = 0; n_fail = 0;
        test_reset();
        test_mult();
        test_multu();
        test_div();
        test_div0();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid();
`ifdef MDU_ABORT_EN
        test_abort();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
